// File: rtl/cook_program_sequencer.sv
// cook_program_sequencer
//   Stores up to four cooking stages {power, seconds} and plays them back in
//   order. Heater drive, door interlock, pause/resume, cancel and completion
//   pulse are handled here. One cooking second is TICKS_PER_SEC clk cycles.
//
// Ports
//   clk, reset             system clock, async active-high reset
//   door_status            1 = door closed
//   start_button           raw start level (rising edge = start)
//   cancel_button          cancel level (highest priority)
//   load_valid/power/time  stage-load request; load_ready acknowledges
//   heater_en, power_out   heater drive and power of the active stage
//   time_remaining         seconds left in the active stage
//   stage_idx, stage_count active stage (0-based) and number stored
//   state_out              IDLE=0 READY=1 COOK=2 PAUSE=3 DONE=4
//   done_pulse             one cycle at program completion
//
// state | meaning
// IDLE  | empty program, waiting for the first stage load
// READY | program loaded, waiting for start with the door closed
// COOK  | heater on, active stage counting down
// PAUSE | door was opened while cooking; stage and time frozen
// DONE  | program finished; waits for door open or cancel
module cook_program_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_status,
  input  logic       start_button,
  input  logic       cancel_button,
  input  logic       load_valid,
  input  logic       load_power,
  input  logic [6:0] load_time,
  output logic       load_ready,
  output logic       heater_en,
  output logic       power_out,
  output logic [6:0] time_remaining,
  output logic [1:0] stage_idx,
  output logic [2:0] stage_count,
  output logic [2:0] state_out,
  output logic       done_pulse
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [6:0]    time_n;
  logic          power_n;
  logic [1:0]    idx_n;
  logic [2:0]    count_n;
  logic          done_n;
  logic          start_q;
  logic          start;
  logic          load_fire;
  logic          more_stages;
  logic [1:0]    next_idx;

  logic          pwr_mem  [4];
  logic [6:0]    time_mem [4];

  assign start       = start_button & ~start_q;
  assign load_ready  = ((state == ST_IDLE) || (state == ST_READY)) && (stage_count < 3'd4);
  // zero-length stages are dropped without being stored
  assign load_fire   = load_valid & load_ready & (load_time != 7'd0);
  // heater follows the state register so an async reset removes it at once
  assign heater_en   = (state == ST_COOK);
  assign state_out   = state;
  assign next_idx    = stage_idx + 2'd1;
  assign more_stages = (({1'b0, stage_idx} + 3'd1) < stage_count);

  // program storage needs no reset: stage_count says which entries are valid
  always_ff @(posedge clk) begin
    if (load_fire) begin
      pwr_mem[stage_count[1:0]]  <= load_power;
      time_mem[stage_count[1:0]] <= load_time;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      presc          <= '0;
      time_remaining <= 7'd0;
      power_out      <= 1'b0;
      stage_idx      <= 2'd0;
      stage_count    <= 3'd0;
      done_pulse     <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state          <= state_n;
      presc          <= presc_n;
      time_remaining <= time_n;
      power_out      <= power_n;
      stage_idx      <= idx_n;
      stage_count    <= count_n;
      done_pulse     <= done_n;
      start_q        <= start_button;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    time_n  = time_remaining;
    power_n = power_out;
    idx_n   = stage_idx;
    count_n = stage_count;
    done_n  = 1'b0;

    if (load_fire) begin
      count_n = stage_count + 3'd1;
    end

    if (cancel_button && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      presc_n = '0;
      time_n  = 7'd0;
      power_n = 1'b0;
      idx_n   = 2'd0;
      count_n = 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_fire) state_n = ST_READY;
        end
        ST_READY: begin
          if (start && door_status) begin
            state_n = ST_COOK;
            idx_n   = 2'd0;
            time_n  = time_mem[0];
            power_n = pwr_mem[0];
            presc_n = '0;
          end
        end
        ST_COOK: begin
          if (!door_status) begin
            // door opening wins over a decrement due in the same cycle
            state_n = ST_PAUSE;
            presc_n = '0;
          end else if (presc == PRESC_TC) begin
            presc_n = '0;
            if (time_remaining <= 7'd1) begin
              if (more_stages) begin
                idx_n   = next_idx;
                time_n  = time_mem[next_idx];
                power_n = pwr_mem[next_idx];
              end else begin
                state_n = ST_DONE;
                time_n  = 7'd0;
                done_n  = 1'b1;
              end
            end else begin
              time_n = time_remaining - 7'd1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start && door_status) state_n = ST_COOK;
        end
        ST_DONE: begin
          if (!door_status) begin
            state_n = ST_IDLE;
            presc_n = '0;
            time_n  = 7'd0;
            power_n = 1'b0;
            idx_n   = 2'd0;
            count_n = 3'd0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_program_sequencer.sv
module tb_cook_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       door, sb, cb, lv, lp;
  logic [6:0] lt;

  logic       lr0, he0, po0, dp0, lr1, he1, po1, dp1;
  logic [6:0] tr0, tr1;
  logic [1:0] si0, si1;
  logic [2:0] sc0, so0, sc1, so1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cook_program_sequencer #(.TICKS_PER_SEC(1)) dut0 (
    .clk(clk), .reset(reset), .door_status(door), .start_button(sb),
    .cancel_button(cb), .load_valid(lv), .load_power(lp), .load_time(lt),
    .load_ready(lr0), .heater_en(he0), .power_out(po0), .time_remaining(tr0),
    .stage_idx(si0), .stage_count(sc0), .state_out(so0), .done_pulse(dp0));

  cook_program_sequencer #(.TICKS_PER_SEC(3)) dut1 (
    .clk(clk), .reset(reset), .door_status(door), .start_button(sb),
    .cancel_button(cb), .load_valid(lv), .load_power(lp), .load_time(lt),
    .load_ready(lr1), .heater_en(he1), .power_out(po1), .time_remaining(tr1),
    .stage_idx(si1), .stage_count(sc1), .state_out(so1), .done_pulse(dp1));

  // reference model: one set of fields per instance (0: 1 tick/s, 1: 3 ticks/s)
  int m_st[2], m_cnt[2], m_idx[2], m_tr[2], m_pw[2], m_presc[2], m_done[2], m_sq[2];
  int m_pp[2][4], m_pt[2][4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mclear(input int k);
    m_st[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_tr[k] = 0; m_pw[k] = 0; m_presc[k] = 0;
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mclear(k);
      m_done[k] = 0;
      m_sq[k] = 0;
    end
  endtask

  task automatic mstep(input int k, input int ticks);
    int ost;
    bit sev, rdy, ld;
    ost = m_st[k];
    sev = sb && !m_sq[k];
    m_sq[k] = int'(sb);
    m_done[k] = 0;
    rdy = (ost <= 1) && (m_cnt[k] < 4);
    ld = lv && rdy && (lt != 0);
    if (cb && ost != 0) begin
      mclear(k);
    end else begin
      if (ld) begin
        m_pp[k][m_cnt[k]] = int'(lp);
        m_pt[k][m_cnt[k]] = int'(lt);
        m_cnt[k]++;
        if (ost == 0) m_st[k] = 1;
      end
      case (ost)
        1: if (sev && door) begin
             m_st[k] = 2; m_idx[k] = 0; m_tr[k] = m_pt[k][0]; m_pw[k] = m_pp[k][0]; m_presc[k] = 0;
           end
        2: if (!door) begin
             m_st[k] = 3; m_presc[k] = 0;
           end else if (m_presc[k] == ticks - 1) begin
             m_presc[k] = 0;
             m_tr[k]--;
             if (m_tr[k] == 0) begin
               if (m_idx[k] + 1 < m_cnt[k]) begin
                 m_idx[k]++;
                 m_tr[k] = m_pt[k][m_idx[k]];
                 m_pw[k] = m_pp[k][m_idx[k]];
               end else begin
                 m_st[k] = 4; m_done[k] = 1;
               end
             end
           end else begin
             m_presc[k]++;
           end
        3: if (sev && door) m_st[k] = 2;
        4: if (!door) mclear(k);
        default: ;
      endcase
    end
  endtask

  task automatic chk_inst(input int k, input int so, input int sc, input int si, input int tr,
                          input int po, input int he, input int dp, input int lr);
    chk($sformatf("i%0d.state", k), so, m_st[k]);
    chk($sformatf("i%0d.count", k), sc, m_cnt[k]);
    chk($sformatf("i%0d.idx", k), si, m_idx[k]);
    chk($sformatf("i%0d.time", k), tr, m_tr[k]);
    chk($sformatf("i%0d.power", k), po, m_pw[k]);
    chk($sformatf("i%0d.heater", k), he, int'(m_st[k] == 2));
    chk($sformatf("i%0d.done", k), dp, m_done[k]);
    chk($sformatf("i%0d.ready", k), lr, int'(m_st[k] <= 1 && m_cnt[k] < 4));
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep(0, 1);
    mstep(1, 3);
    #1;
    chk_inst(0, so0, sc0, si0, tr0, po0, he0, dp0, lr0);
    chk_inst(1, so1, sc1, si1, tr1, po1, he1, dp1, lr1);
  endtask

  task automatic idle_inputs();
    sb = 0; cb = 0; lv = 0; lp = 0; lt = 0; door = 1;
  endtask

  task automatic sync();
    idle_inputs();
    cb = 1; cycle();
    cb = 0; cycle();
  endtask

  task automatic load(input logic p, input logic [6:0] t);
    lv = 1; lp = p; lt = t; cycle();
    lv = 0; lt = 0;
  endtask

  task automatic press_start();
    sb = 1; cycle();
    sb = 0;
  endtask

  typedef struct {
    logic door, sb, cb, lv, lp;
    logic [6:0] lt;
    int e_st, e_cnt, e_idx, e_tr, e_pw, e_heat, e_done, e_rdy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int heat, pulses, n0, n1, guard;
    bit tout;

    tbl[0]  = '{1, 0, 0, 1, 1, 7'd2, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 1, 0, 7'd0, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 1, 0, 7'd1, 1, 2, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 0, 7'd0, 1, 2, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 0, 0, 7'd0, 1, 2, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 0, 7'd0, 2, 2, 0, 2, 1, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 7'd0, 2, 2, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 7'd0, 2, 2, 1, 1, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 7'd0, 4, 2, 1, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 7'd0, 4, 2, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 1};

    idle_inputs();
    reset = 1;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", int'(so0), 0);
    chk("rst.heater", int'(he0), 0);
    chk("rst.ready", int'(lr0), 1);
    reset = 0;

    // directed table on the 1 tick/s instance
    for (int i = 0; i < 11; i++) begin
      door = tbl[i].door; sb = tbl[i].sb; cb = tbl[i].cb;
      lv = tbl[i].lv; lp = tbl[i].lp; lt = tbl[i].lt;
      cycle();
      chk($sformatf("tbl%0d.state", i), int'(so0), tbl[i].e_st);
      chk($sformatf("tbl%0d.count", i), int'(sc0), tbl[i].e_cnt);
      chk($sformatf("tbl%0d.idx", i), int'(si0), tbl[i].e_idx);
      chk($sformatf("tbl%0d.time", i), int'(tr0), tbl[i].e_tr);
      chk($sformatf("tbl%0d.power", i), int'(po0), tbl[i].e_pw);
      chk($sformatf("tbl%0d.heater", i), int'(he0), tbl[i].e_heat);
      chk($sformatf("tbl%0d.done", i), int'(dp0), tbl[i].e_done);
      chk($sformatf("tbl%0d.ready", i), int'(lr0), tbl[i].e_rdy);
    end

    // single 5 s stage: heater exactly 5 cycles, one done pulse
    sync();
    load(1, 7'd5);
    press_start();
    chk("s5.first_state", int'(so0), 2);
    chk("s5.first_time", int'(tr0), 5);
    heat = int'(he0); pulses = 0; tout = 1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      heat += int'(he0);
      pulses += int'(dp0);
      if (so0 == 3'd4) begin tout = 0; break; end
    end
    chk("s5.timeout", int'(tout), 0);
    chk("s5.heat_cycles", heat, 5);
    chk("s5.pulses", pulses, 1);
    cycle();
    chk("s5.pulse_drop", int'(dp0), 0);

    // two stages: 3 s full then 2 s half
    sync();
    load(1, 7'd3);
    load(0, 7'd2);
    press_start();
    n0 = 0; n1 = 0; tout = 1;
    for (int c = 0; c < 40; c++) begin
      if (so0 == 3'd2 && si0 == 2'd0 && po0) n0++;
      if (so0 == 3'd2 && si0 == 2'd1 && !po0) n1++;
      cycle();
      if (so0 == 3'd4) begin tout = 0; break; end
    end
    chk("two.timeout", int'(tout), 0);
    chk("two.stage0_secs", n0, 3);
    chk("two.stage1_secs", n1, 2);

    // pause at 30 s, resume, finish
    sync();
    load(1, 7'd40);
    press_start();
    guard = 0;
    while (tr0 != 7'd30 && guard < 60) begin cycle(); guard++; end
    chk("pause.reach30", int'(tr0), 30);
    door = 0; cycle();
    chk("pause.state", int'(so0), 3);
    chk("pause.heater", int'(he0), 0);
    chk("pause.time", int'(tr0), 30);
    door = 1; cycle();
    chk("pause.hold_time", int'(tr0), 30);
    press_start();
    chk("resume.state", int'(so0), 2);
    chk("resume.time", int'(tr0), 30);
    heat = int'(he0); tout = 1;
    for (int c = 0; c < 60; c++) begin
      cycle();
      heat += int'(he0);
      if (so0 == 3'd4) begin tout = 0; break; end
    end
    chk("resume.timeout", int'(tout), 0);
    chk("resume.heat_cycles", heat, 30);
    chk("resume.end_time", int'(tr0), 0);

    // list full
    sync();
    for (int i = 0; i < 4; i++) load(1'(i), 7'(i + 1));
    chk("full.ready", int'(lr0), 0);
    chk("full.count", int'(sc0), 4);
    load(1, 7'd9);
    chk("full.count_after", int'(sc0), 4);

    // cancel beats start
    sync();
    load(1, 7'd4);
    sb = 1; cb = 1; cycle();
    sb = 0; cb = 0;
    chk("cancel.state", int'(so0), 0);
    chk("cancel.count", int'(sc0), 0);

    // async reset mid-cook
    sync();
    load(1, 7'd9);
    press_start();
    cycle();
    chk("arst.pre_heater", int'(he0), 1);
    reset = 1;
    #1;
    chk("arst.heater", int'(he0), 0);
    chk("arst.state", int'(so0), 0);
    chk("arst.time", int'(tr0), 0);
    chk("arst.power", int'(po0), 0);
    chk("arst.count", int'(sc0), 0);
    chk("arst.idx", int'(si0), 0);
    chk("arst.heater1", int'(he1), 0);
    mreset();
    @(posedge clk);
    #1;
    reset = 0;

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      door = ($urandom_range(0, 99) < 92);
      sb   = ($urandom_range(0, 99) < 25);
      cb   = ($urandom_range(0, 199) < 3);
      lv   = ($urandom_range(0, 99) < 30);
      lp   = 1'($urandom_range(0, 1));
      lt   = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
